// File: rtl/op_stack_bank.sv
// op_stack_bank -- bank of NCH independent LIFO stacks, one per channel.
//
// Each channel takes its own stack command (NON/PUS/POP/TOP/CLR) and has its
// own registered read port. Read latency is one cycle. There is no stall: a
// new command can be issued on every channel in every cycle.
//
// Optional build macro: OP_STACK_GUARD_EN
//   defined   : misuse (push when full, pop/top when empty) is ignored,
//               drops rvalid and sets a sticky err that clears on CLR/Reset.
//   undefined : err is tied 0. A push when full overwrites the top slot,
//               and a pop/top when empty returns 0 with rvalid=1.
//
// Ports (channel c owns slice c of every bus):
//   Clock  - rising-edge clock
//   Reset  - synchronous, active-high; wins over any command
//   cmd    - NCH*`SC_N  per-channel command (unknown codes act as NON)
//   wdata  - NCH*WIDTH  push data
//   rdata  - NCH*WIDTH  registered top-of-stack result
//   rvalid - NCH        rdata updated by the previous command
//   empty  - NCH        count == 0
//   full   - NCH        count == DEPTH
//   count  - NCH*(AW+1) occupancy
//   err    - NCH        sticky misuse flag

`ifndef SC_N
`define SC_N   3
`define SC_NON 3'd0
`define SC_PUS 3'd1
`define SC_POP 3'd2
`define SC_TOP 3'd3
`define SC_CLR 3'd4
`endif

module op_stack_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [`SC_N-1:0] cmd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             err
);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] rd_q;
    logic             rv_q;
    logic             is_pus, is_pop, is_top, is_clr;
    logic             mem_we;
    logic [AW-1:0]    wr_ptr, rd_ptr;

    assign is_pus = (cmd == `SC_PUS);
    assign is_pop = (cmd == `SC_POP);
    assign is_top = (cmd == `SC_TOP);
    assign is_clr = (cmd == `SC_CLR);

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CNT_MAX);
    assign count  = cnt_q;
    assign rdata  = rd_q;
    assign rvalid = rv_q;

    // Top entry lives at count-1; the read always uses the pre-edge count.
    assign rd_ptr = AW'(cnt_q - 1'b1);
    // When full, the only write that can happen is the overwrite of the top slot.
    assign wr_ptr = full ? AW'(DEPTH - 1) : cnt_q[AW-1:0];

`ifdef OP_STACK_GUARD_EN
    assign mem_we = is_pus && !full;
`else
    assign mem_we = is_pus;
`endif

    // Storage is not reset; a push coinciding with Reset is discarded.
    always_ff @(posedge Clock) begin
        if (!Reset && mem_we)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
            rd_q  <= '0;
            rv_q  <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            case (cmd)
                `SC_PUS: begin
                    if (!full) begin
                        cnt_q <= cnt_q + 1'b1;
                        rd_q  <= wdata;
                        rv_q  <= 1'b1;
                    end else begin
`ifndef OP_STACK_GUARD_EN
                        rd_q  <= wdata;
                        rv_q  <= 1'b1;
`endif
                    end
                end
                `SC_POP: begin
                    if (!empty) begin
                        rd_q  <= mem[rd_ptr];
                        cnt_q <= cnt_q - 1'b1;
                        rv_q  <= 1'b1;
                    end else begin
`ifndef OP_STACK_GUARD_EN
                        rd_q  <= '0;
                        rv_q  <= 1'b1;
`endif
                    end
                end
                `SC_TOP: begin
                    if (!empty) begin
                        rd_q  <= mem[rd_ptr];
                        rv_q  <= 1'b1;
                    end else begin
`ifndef OP_STACK_GUARD_EN
                        rd_q  <= '0;
                        rv_q  <= 1'b1;
`endif
                    end
                end
                `SC_CLR: cnt_q <= '0;
                default: ;
            endcase
        end
    end

`ifdef OP_STACK_GUARD_EN
    logic misuse;
    logic err_q;

    assign misuse = (is_pus && full) || ((is_pop || is_top) && empty);
    assign err    = err_q;

    always_ff @(posedge Clock) begin
        if (Reset || is_clr)
            err_q <= 1'b0;
        else if (misuse)
            err_q <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

module op_stack_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NCH   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NCH*`SC_N-1:0]   cmd,
    input  logic [NCH*WIDTH-1:0]   wdata,
    output logic [NCH*WIDTH-1:0]   rdata,
    output logic [NCH-1:0]         rvalid,
    output logic [NCH-1:0]         empty,
    output logic [NCH-1:0]         full,
    output logic [NCH*(AW+1)-1:0]  count,
    output logic [NCH-1:0]         err
);
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        op_stack_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .Clock  (Clock),
            .Reset  (Reset),
            .cmd    (cmd[c*`SC_N +: `SC_N]),
            .wdata  (wdata[c*WIDTH +: WIDTH]),
            .rdata  (rdata[c*WIDTH +: WIDTH]),
            .rvalid (rvalid[c]),
            .empty  (empty[c]),
            .full   (full[c]),
            .count  (count[c*(AW+1) +: (AW+1)]),
            .err    (err[c])
        );
    end

endmodule

// File: tb/tb_op_stack_bank.sv
// Scoreboard bench for op_stack_bank (WIDTH=8, DEPTH=16, NCH=2).
// The driver issues directed commands and queues hand-computed per-channel
// expectations tagged with the cycle they become visible; an independent
// monitor pops and compares them on the falling edge.

`ifndef SC_N
`define SC_N   3
`define SC_NON 3'd0
`define SC_PUS 3'd1
`define SC_POP 3'd2
`define SC_TOP 3'd3
`define SC_CLR 3'd4
`endif

module tb_op_stack_bank;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int N  = 2;
    localparam int CW = 5;

`ifdef OP_STACK_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    localparam logic [2:0] NON = `SC_NON;
    localparam logic [2:0] PUS = `SC_PUS;
    localparam logic [2:0] POP = `SC_POP;
    localparam logic [2:0] TOP = `SC_TOP;
    localparam logic [2:0] CLR = `SC_CLR;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [N*3-1:0]    cmd   = '0;
    logic [N*W-1:0]    wdata = '0;
    logic [N*W-1:0]    rdata;
    logic [N-1:0]      rvalid, empty, full, err;
    logic [N*CW-1:0]   count;

    op_stack_bank #(.WIDTH(W), .DEPTH(D), .NCH(N)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .cmd    (cmd),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .empty  (empty),
        .full   (full),
        .count  (count),
        .err    (err)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         ch;
        string      nm;
        logic [7:0] rd;
        bit         chk_rd;
        logic       rv;
        logic [4:0] cnt;
        logic       er;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h (t=%0t)", nm, fld, act, req, $time);
        end
    endtask

    // Monitor: compares every expectation due at the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk(e.nm, "cycle", cyc, e.cyc);
                chk(e.nm, "rvalid", rvalid[e.ch], e.rv);
                chk(e.nm, "count", count[e.ch*CW +: CW], e.cnt);
                chk(e.nm, "empty", empty[e.ch], (e.cnt == 0));
                chk(e.nm, "full", full[e.ch], (e.cnt == 5'd16));
                chk(e.nm, "err", err[e.ch], e.er);
                if (e.chk_rd)
                    chk(e.nm, "rdata", rdata[e.ch*W +: W], e.rd);
            end
        end
    end

    // Drive one command set, sampled at the next rising edge.
    task automatic drive(input logic rst, input logic [2:0] c0, input logic [7:0] w0,
                         input logic [2:0] c1, input logic [7:0] w1);
        @(posedge Clock);
        #1;
        Reset = rst;
        cmd   = {c1, c0};
        wdata = {w1, w0};
    endtask

    // Expectation for the cycle after the command just driven.
    task automatic ex(input int ch, input string nm, input logic [7:0] rd, input bit chk_rd,
                      input logic rv, input logic [4:0] cnt, input logic er);
        exp_t e;
        e.cyc = cyc + 1; e.ch = ch; e.nm = nm; e.rd = rd; e.chk_rd = chk_rd;
        e.rv = rv; e.cnt = cnt; e.er = er;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        drive(1, NON, 8'h00, NON, 8'h00);
        ex(0, "rst0", 8'h00, 1, 0, 0, 0);
        ex(1, "rst1", 8'h00, 1, 0, 0, 0);

        // Three pushes on ch0, ch1 idle
        drive(0, PUS, 8'h11, NON, 8'h00); ex(0, "pus11", 8'h11, 1, 1, 1, 0);
        drive(0, PUS, 8'h22, NON, 8'h00); ex(0, "pus22", 8'h22, 1, 1, 2, 0);
        drive(0, PUS, 8'h33, NON, 8'h00); ex(0, "pus33", 8'h33, 1, 1, 3, 0);
        ex(1, "ch1_idle", 8'h00, 1, 0, 0, 0);

        // Pop back in LIFO order
        drive(0, POP, 8'h00, NON, 8'h00); ex(0, "pop33", 8'h33, 1, 1, 2, 0);
        drive(0, POP, 8'h00, NON, 8'h00); ex(0, "pop22", 8'h22, 1, 1, 1, 0);
        drive(0, POP, 8'h00, NON, 8'h00); ex(0, "pop11", 8'h11, 1, 1, 0, 0);
        drive(0, NON, 8'h00, NON, 8'h00); ex(0, "non_hold", 8'h11, 1, 0, 0, 0);

        // Simultaneous pushes, then TOP on both
        drive(0, PUS, 8'hA5, PUS, 8'h5A);
        ex(0, "dual_pus0", 8'hA5, 1, 1, 1, 0); ex(1, "dual_pus1", 8'h5A, 1, 1, 1, 0);
        drive(0, TOP, 8'h00, TOP, 8'h00);
        ex(0, "dual_top0", 8'hA5, 1, 1, 1, 0); ex(1, "dual_top1", 8'h5A, 1, 1, 1, 0);
        drive(0, CLR, 8'h00, CLR, 8'h00);
        ex(0, "clr0", 8'hA5, 1, 0, 0, 0); ex(1, "clr1", 8'h5A, 1, 0, 0, 0);

        // Fill ch0 to DEPTH
        for (int i = 0; i < D; i++) begin
            drive(0, PUS, 8'(i), NON, 8'h00);
            ex(0, "fill", 8'(i), 1, 1, 5'(i + 1), 0);
        end

        // Push while full
        drive(0, PUS, 8'hFF, NON, 8'h00);
        ex(0, "pus_full", G ? 8'h0F : 8'hFF, 1, G ? 1'b0 : 1'b1, 16, G);
        drive(0, POP, 8'h00, NON, 8'h00);
        ex(0, "pop_after_full", G ? 8'h0F : 8'hFF, 1, 1, 15, G);

        // Pop / top on empty ch1
        drive(0, NON, 8'h00, POP, 8'h00);
        ex(1, "pop_empty", G ? 8'h5A : 8'h00, 1, G ? 1'b0 : 1'b1, 0, G);
        drive(0, NON, 8'h00, TOP, 8'h00);
        ex(1, "top_empty", G ? 8'h5A : 8'h00, 1, G ? 1'b0 : 1'b1, 0, G);
        drive(0, CLR, 8'h00, CLR, 8'h00);
        ex(0, "clr_full0", G ? 8'h0F : 8'hFF, 1, 0, 0, 0);
        ex(1, "clr_err1", G ? 8'h5A : 8'h00, 1, 0, 0, 0);

        // PUS then POP restores count and returns the value
        drive(0, NON, 8'h00, PUS, 8'h42); ex(1, "pus42", 8'h42, 1, 1, 1, 0);
        drive(0, NON, 8'h00, POP, 8'h00); ex(1, "pop42", 8'h42, 1, 1, 0, 0);

        // Push on the reset edge is discarded
        drive(0, PUS, 8'h10, NON, 8'h00); ex(0, "pre_rst", 8'h10, 1, 1, 1, 0);
        drive(1, PUS, 8'h77, NON, 8'h00);
        ex(0, "rst_pus0", 8'h00, 1, 0, 0, 0); ex(1, "rst_pus1", 8'h00, 1, 0, 0, 0);
        drive(0, TOP, 8'h00, NON, 8'h00);
        ex(0, "top_after_rst", 8'h00, 1, G ? 1'b0 : 1'b1, 0, G);
        drive(0, CLR, 8'h00, NON, 8'h00); ex(0, "final_clr", 8'h00, 1, 0, 0, 0);

        // Drain the scoreboard
        drive(0, NON, 8'h00, NON, 8'h00);
        drive(0, NON, 8'h00, NON, 8'h00);
        @(negedge Clock);
        #1;
        chk("sb", "pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
